parking_slot_allocator: RTL

Sequential front end of the parking datapath. Accepts car entry and exit events, allocates the lowest free slot on entry, frees the named slot on exit, and runs the entry-gate timing FSM. Its registered `occupancy` vector is the direct input of the downstream ones counter, which reports the number of parked cars.

---
 rtl/parking_pkg.sv | 12 +
 rtl/lowest_free_slot.sv | 23 ++
 rtl/parking_slot_allocator.sv | 124 ++++++++++++
 3 files changed

// File: rtl/parking_pkg.sv
// Shared types and defaults for the parking datapath.
package parking_pkg;

  typedef enum logic {
    IDLE,
    GATE
  } state_t;

  localparam int DEF_SLOTS       = 8;
  localparam int DEF_GATE_CYCLES = 4;

endpackage

// File: rtl/lowest_free_slot.sv
// Priority encoder: index of the lowest set bit of a free-mask.
module lowest_free_slot #(
  parameter  int N = 8,
  localparam int W = $clog2(N)
) (
  input  logic [N-1:0] i_free,
  output logic [W-1:0] o_idx,
  output logic         o_found
);

  always_comb begin
    o_idx   = '0;
    o_found = 1'b0;
    // Scan downward so the lowest set bit is the last one written.
    for (int i = N - 1; i >= 0; i--) begin
      if (i_free[i]) begin
        o_idx   = W'(i);
        o_found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/parking_slot_allocator.sv
// Entry/exit slot allocator with entry-gate timing FSM.
// Optional reserved VIP slot (SLOTS-1) when PARKING_VIP_SLOT_EN is defined.
module parking_slot_allocator
  import parking_pkg::*;
#(
  parameter  int SLOTS       = DEF_SLOTS,
  parameter  int GATE_CYCLES = DEF_GATE_CYCLES,
  localparam int SW          = $clog2(SLOTS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             entry_req,
  input  logic             entry_vip,
  input  logic             exit_req,
  input  logic [SW-1:0]    exit_slot,
  output logic             entry_ack,
  output logic [SW-1:0]    entry_slot,
  output logic             entry_full,
  output logic             exit_err,
  output logic             gate_open,
  output logic [SLOTS-1:0] occupancy
);

  localparam int CW = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
  localparam logic [CW-1:0] GATE_LOAD = CW'(GATE_CYCLES - 1);

  state_t           r_state;
  logic [CW-1:0]    r_cnt;
  logic [SLOTS-1:0] r_occ;
  logic [SW-1:0]    r_slot;
  logic             r_ack;
  logic             r_full;
  logic             r_err;
  logic             r_gate;

  logic [SLOTS-1:0] w_free;
  logic [SLOTS-1:0] w_elig;
  logic [SLOTS-1:0] w_set;
  logic [SLOTS-1:0] w_clr;
  logic [SW-1:0]    w_enc_idx;
  logic [SW-1:0]    w_pick;
  logic             w_enc_found;
  logic             w_can_admit;
  logic             w_try;
  logic             w_admit;
  logic             w_in_range;
  logic             w_exit_ok;

  assign w_free = ~r_occ;

`ifdef PARKING_VIP_SLOT_EN
  logic w_vip_hit;
  assign w_elig      = w_free & {1'b0, {(SLOTS-1){1'b1}}};
  assign w_vip_hit   = entry_vip & w_free[SLOTS-1];
  assign w_pick      = w_vip_hit ? SW'(SLOTS - 1) : w_enc_idx;
  assign w_can_admit = w_vip_hit | w_enc_found;
`else
  logic w_unused_vip;
  assign w_unused_vip = entry_vip;
  assign w_elig       = w_free;
  assign w_pick       = w_enc_idx;
  assign w_can_admit  = w_enc_found;
`endif

  lowest_free_slot #(
    .N(SLOTS)
  ) u_lfs (
    .i_free (w_elig),
    .o_idx  (w_enc_idx),
    .o_found(w_enc_found)
  );

  // Both paths read the occupancy registered at the start of the cycle.
  assign w_try      = (r_state == IDLE) & entry_req;
  assign w_admit    = w_try & w_can_admit;
  assign w_in_range = ({1'b0, exit_slot} < (SW + 1)'(SLOTS));
  assign w_exit_ok  = exit_req & w_in_range & r_occ[exit_slot];
  assign w_set      = w_admit ? (SLOTS'(1) << w_pick) : '0;
  assign w_clr      = w_exit_ok ? (SLOTS'(1) << exit_slot) : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_occ   <= '0;
      r_slot  <= '0;
      r_ack   <= 1'b0;
      r_full  <= 1'b0;
      r_err   <= 1'b0;
      r_gate  <= 1'b0;
    end else begin
      r_occ  <= (r_occ | w_set) & ~w_clr;
      r_err  <= exit_req & ~w_exit_ok;
      r_ack  <= w_admit;
      r_full <= w_try & ~w_can_admit;
      if (w_admit) r_slot <= w_pick;
      unique case (r_state)
        IDLE: begin
          if (w_admit) begin
            r_state <= GATE;
            r_cnt   <= GATE_LOAD;
            r_gate  <= 1'b1;
          end
        end
        GATE: begin
          if (r_cnt == '0) begin
            r_state <= IDLE;
            r_gate  <= 1'b0;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
      endcase
    end
  end

  assign entry_ack  = r_ack;
  assign entry_slot = r_slot;
  assign entry_full = r_full;
  assign exit_err   = r_err;
  assign gate_open  = r_gate;
  assign occupancy  = r_occ;

endmodule
